// File: rtl/vga_frame_timer.sv
// Raster timing generator: pixel/line counters, pipelined sync/enable decode,
// frame-boundary mode latch and a free-running frame counter.
module vga_frame_timer #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [2:0]  mode_req,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        hsync,
  output logic        vsync,
  output logic        vde,
  output logic        frame_start,
  output logic        start_state,
  output logic        game_state,
  output logic        wait_state,
  output logic [15:0] frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [2:0] MODE_START = 3'b001;

  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        fs_q, fs_d;
  logic [15:0] fc_q, fc_d;
  logic [2:0]  mode_q, mode_d;
  logic        line_end, frame_end, mode_req_valid;
  logic        hs_n, vs_n, de;

  logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
  logic [PIPE_DELAY-1:0] de_pipe_q, de_pipe_d;

  assign mode_req_valid = (mode_req == 3'b001) || (mode_req == 3'b010) ||
                          (mode_req == 3'b100);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    x_d       = x_q;
    y_d       = y_q;
    fc_d      = fc_q;
    mode_d    = mode_q;
    line_end  = (x_q == X_LAST);
    frame_end = pix_en && line_end && (y_q == Y_LAST);
    if (pix_en) begin
      if (line_end) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    // The wrap cycle decides the next frame's mode; a malformed request keeps the old one.
    fs_d = frame_end;
    if (frame_end) begin
      fc_d = fc_q + 16'd1;
      if (mode_req_valid) mode_d = mode_req;
    end
  end

  assign hs_n = !((x_q >= HS_FIRST) && (x_q <= HS_LAST));
  assign vs_n = !((y_q >= VS_FIRST) && (y_q <= VS_LAST));
  assign de   = (x_q < X_VIS) && (y_q < Y_VIS);

  if (PIPE_DELAY == 1) begin : g_pipe_single
    assign hs_pipe_d = hs_n;
    assign vs_pipe_d = vs_n;
    assign de_pipe_d = de;
  end else begin : g_pipe_multi
    assign hs_pipe_d = {hs_pipe_q[PIPE_DELAY-2:0], hs_n};
    assign vs_pipe_d = {vs_pipe_q[PIPE_DELAY-2:0], vs_n};
    assign de_pipe_d = {de_pipe_q[PIPE_DELAY-2:0], de};
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      fs_q      <= 1'b0;
      fc_q      <= '0;
      mode_q    <= MODE_START;
      // NOTE: the delay line is reset to idle levels so no stale sync pulse leaks out after reset.
      hs_pipe_q <= '1;
      vs_pipe_q <= '1;
      de_pipe_q <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      fs_q      <= fs_d;
      fc_q      <= fc_d;
      mode_q    <= mode_d;
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
      de_pipe_q <= de_pipe_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign hsync       = hs_pipe_q[PIPE_DELAY-1];
  assign vsync       = vs_pipe_q[PIPE_DELAY-1];
  assign vde         = de_pipe_q[PIPE_DELAY-1];
  assign frame_start = fs_q;
  assign frame_count = fc_q;
  assign start_state = mode_q[0];
  assign game_state  = mode_q[1];
  assign wait_state  = mode_q[2];

endmodule

// File: tb/tb_vga_frame_timer.sv
// Bench for vga_frame_timer on a shrunken raster, checked every cycle against a
// pixel-index reference model plus directed timing measurements.
module tb_vga_frame_timer;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int PD = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  logic        clk = 1'b0;
  logic        reset, pix_en;
  logic [2:0]  mode_req;
  logic [9:0]  DrawX, DrawY;
  logic        hsync, vsync, vde, frame_start;
  logic        start_state, game_state, wait_state;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  vga_frame_timer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIPE_DELAY(PD)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .mode_req(mode_req),
    .DrawX(DrawX), .DrawY(DrawY), .hsync(hsync), .vsync(vsync), .vde(vde),
    .frame_start(frame_start), .start_state(start_state),
    .game_state(game_state), .wait_state(wait_state), .frame_count(frame_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: raster position as a linear pixel index within the frame.
  int          m_p;
  logic        m_fs;
  logic [15:0] m_fc;
  logic [2:0]  m_mode;
  sync_t       m_q[$];

  logic [2:0]  req;
  logic        pe_phase = 1'b1;

  function automatic sync_t decode(input int p);
    sync_t r;
    int x, y;
    x = p % HT;
    y = p / HT;
    r.hs = !(x >= HA + HF && x < HA + HF + HS);
    r.vs = !(y >= VA + VF && y < VA + VF + VS);
    r.de = (x < HA) && (y < VA);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic pe, input logic [2:0] mr);
    if (r) begin
      m_p    = 0;
      m_fs   = 1'b0;
      m_fc   = '0;
      m_mode = 3'b001;
      m_q.delete();
      repeat (PD) m_q.push_back(sync_t'{1'b1, 1'b1, 1'b0});
    end else begin
      m_q.push_back(decode(m_p));
      while (m_q.size() > PD) void'(m_q.pop_front());
      m_fs = pe && (m_p == FT - 1);
      if (pe) m_p = (m_p + 1) % FT;
      if (m_fs) begin
        m_fc = m_fc + 16'd1;
        if ($countones(mr) == 1) m_mode = mr;
      end
    end
  endtask

  task automatic compare_all();
    check("DrawX", 32'(DrawX), m_p % HT);
    check("DrawY", 32'(DrawY), m_p / HT);
    check("hsync", 32'(hsync), 32'(m_q[0].hs));
    check("vsync", 32'(vsync), 32'(m_q[0].vs));
    check("vde", 32'(vde), 32'(m_q[0].de));
    check("frame_start", 32'(frame_start), 32'(m_fs));
    check("frame_count", 32'(frame_count), 32'(m_fc));
    check("mode", 32'({wait_state, game_state, start_state}), 32'(m_mode));
  endtask

  // Inputs change at the falling edge; outputs are compared at the next falling edge.
  task automatic tick(input logic r, input logic pe, input logic [2:0] mr);
    reset    = r;
    pix_en   = pe;
    mode_req = mr;
    @(posedge clk);
    model_update(r, pe, mr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_fs(input bit toggle, output int n);
    n = 0;
    do begin
      tick(1'b0, toggle ? pe_phase : 1'b1, req);
      if (toggle) pe_phase = ~pe_phase;
      n++;
    end while (frame_start !== 1'b1 && n < 3 * FT);
    check("fs_seen", 32'(frame_start), 1);
  endtask

  task automatic goto_xy(input int x, input int y);
    int n = 0;
    while (!(DrawX == 10'(x) && DrawY == 10'(y)) && n < 2 * FT) begin
      tick(1'b0, 1'b1, req);
      n++;
    end
    check("goto_x", 32'(DrawX), x);
    check("goto_y", 32'(DrawY), y);
  endtask

  initial begin
    int n, m;
    reset    = 1'b1;
    pix_en   = 1'b1;
    mode_req = 3'b001;
    req      = 3'b001;
    @(negedge clk);

    // Reset held for 10 clocks.
    repeat (10) tick(1'b1, 1'b1, 3'b100);
    check("rst_DrawX", 32'(DrawX), 0);
    check("rst_DrawY", 32'(DrawY), 0);
    check("rst_hsync", 32'(hsync), 1);
    check("rst_vsync", 32'(vsync), 1);
    check("rst_vde", 32'(vde), 0);
    check("rst_fs", 32'(frame_start), 0);
    check("rst_start", 32'(start_state), 1);
    check("rst_fc", 32'(frame_count), 0);

    // Three frames at full pixel rate.
    for (int k = 1; k <= 3; k++) begin
      wait_fs(1'b0, n);
      check("fs_period", n, FT);
      check("fc_after_fs", 32'(frame_count), k);
    end

    // At (0,0): measure hsync fall and width.
    n = 0;
    while (hsync !== 1'b0 && n < 2 * HT) begin tick(1'b0, 1'b1, req); n++; end
    check("hs_fall", n, HA + HF + PD);
    m = 0;
    while (hsync === 1'b0 && m < HT) begin tick(1'b0, 1'b1, req); m++; end
    check("hs_width", m, HS);

    n = 0;
    while (vsync !== 1'b0 && n < 2 * FT) begin tick(1'b0, 1'b1, req); n++; end
    m = 0;
    while (vsync === 1'b0 && m < 2 * FT) begin tick(1'b0, 1'b1, req); m++; end
    check("vs_width", m, VS * HT);

    // Mode request mid-frame only takes effect at the next frame start.
    goto_xy(0, VA / 2);
    req = 3'b010;
    goto_xy(HT - 1, VT - 1);
    check("game_pre_fs", 32'(game_state), 0);
    tick(1'b0, 1'b1, req);
    check("fs_mode", 32'(frame_start), 1);
    check("game_at_fs", 32'(game_state), 1);

    // Malformed request across a boundary holds the mode.
    req = 3'b011;
    wait_fs(1'b0, n);
    check("hold_game", 32'(game_state), 1);
    check("hold_start", 32'(start_state), 0);

    // pix_en alternating 1,0.
    pe_phase = 1'b1;
    wait_fs(1'b1, n);
    tick(1'b0, pe_phase, req);
    pe_phase = ~pe_phase;
    check("fs_one_clk", 32'(frame_start), 0);
    check("held_x0", 32'(DrawX), 0);
    check("held_y0", 32'(DrawY), 0);
    wait_fs(1'b1, n);
    check("fs_period_half", n, 2 * FT - 1);

    // Randomised enable, mode requests and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) req = 3'($urandom_range(0, 7));
      tick(($urandom_range(0, 999) == 0), ($urandom_range(0, 3) != 0), req);
    end

    // Reset mid-frame, during horizontal sync of an active line.
    req = 3'b010;
    goto_xy(HA + HF + 1, VA - 2);
    tick(1'b1, 1'b1, req);
    check("mid_rst_x", 32'(DrawX), 0);
    check("mid_rst_y", 32'(DrawY), 0);
    check("mid_rst_hs", 32'(hsync), 1);
    check("mid_rst_vde", 32'(vde), 0);
    check("mid_rst_start", 32'(start_state), 1);
    wait_fs(1'b0, n);
    check("mid_rst_fs_lat", n, FT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
